// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO holding fetched {pc+4, instr} pairs; flush beats push.
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int W      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [QDEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]            r_wr, r_rd;
  logic [CW-1:0]            r_cnt;
  logic                     w_do_push, w_do_pop;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(QDEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-queue push needs.
  assign w_do_push = push & (~full | w_do_pop) & ~flush;
  assign rdata     = r_mem[r_rd];
  assign count     = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake, queues fetches for ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter bit BOOT_PC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_initial,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc4,
  output logic               misalign_err
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_drain_addr, w_drain_addr_nxt;
  logic          r_misalign, w_mis_set;
  logic          w_req, w_use_drain, w_push, w_pop, w_flush, w_slot;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wentry, w_head;

  assign w_pop    = if_valid & ~stall & ~redirect_valid;
  assign w_slot   = ~w_full | w_pop;
  assign w_wentry = '{pc4: r_fetch_pc + PC_STEP, instr: imem_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .W      ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (w_wentry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_req            = 1'b0;
    w_use_drain      = 1'b0;
    w_push           = 1'b0;
    w_flush          = 1'b0;
    w_mis_set        = 1'b0;
    case (r_state)
      BOOT: begin
        w_fetch_pc_nxt = BOOT_PC_EN ? align_word(pc_initial) : 32'h0;
        w_state_nxt    = FETCH;
      end
      FETCH: begin
        if (w_slot) begin
          w_req = 1'b1;
          if (imem_ack) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          end else begin
            w_state_nxt = WAIT;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      WAIT: begin
        // Nothing was pushed since the request issued, so a slot is still free.
        w_req = 1'b1;
        if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          w_state_nxt    = FETCH;
        end
      end
      HOLD: begin
        if (w_slot) w_state_nxt = FETCH;
      end
      DRAIN: begin
        w_req       = 1'b1;
        w_use_drain = 1'b1;
        if (imem_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = BOOT;
    endcase

    if (redirect_valid && r_state != BOOT) begin
      w_push         = 1'b0;
      w_flush        = 1'b1;
      w_fetch_pc_nxt = align_word(redirect_pc);
      w_mis_set      = |redirect_pc[1:0];
      // An issued request is never aborted; its response is dropped in DRAIN.
      if (w_req && !imem_ack) begin
        w_state_nxt = DRAIN;
        if (r_state != DRAIN) w_drain_addr_nxt = r_fetch_pc;
      end else begin
        w_state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_fetch_pc   <= '0;
      r_drain_addr <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      if (w_mis_set) r_misalign <= 1'b1;
    end
  end

  assign imem_req     = w_req;
  assign imem_addr    = w_req ? (w_use_drain ? r_drain_addr : r_fetch_pc) : 32'h0;
  assign if_valid     = (w_count != '0);
  assign if_instr     = w_empty ? '0 : w_head.instr;
  assign if_pc4       = w_empty ? '0 : w_head.pc4;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised + directed bench for fetch_unit with a PC-stream reference model and scoreboard.
module tb_fetch_unit;
  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_initial;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        misalign_err;

  logic ack_en, ack_force;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_ack   = ack_force | (imem_req & ack_en);
  assign imem_rdata = mem_fn(imem_addr);

  fetch_unit #(.QDEPTH(QDEPTH), .BOOT_PC_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_initial     (pc_initial),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected fetch stream is a PC that advances by 4 per accepted
  // response and jumps on redirect; the pending response at a redirect is discarded.
  logic [63:0] sb[$];
  logic [31:0] m_pc;
  logic        m_drain, m_mis, p_pend;
  logic [31:0] p_addr;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      sb.delete();
      m_pc    = pc_initial & ~32'h3;
      m_drain = 1'b0;
      m_mis   = 1'b0;
      p_pend  = 1'b0;
    end else begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, sb.size() != 0});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      if (p_pend) begin
        chk("req_hold", {31'b0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, p_addr);
      end
      if (if_valid && !stall && !redirect_valid && sb.size() > 0) begin
        e = sb.pop_front();
        chk("if_pc4", if_pc4, e[63:32]);
        chk("if_instr", if_instr, e[31:0]);
      end
      if (redirect_valid) begin
        sb.delete();
        m_pc    = redirect_pc & ~32'h3;
        m_mis   = m_mis | (redirect_pc[1:0] != 2'b00);
        m_drain = imem_req && !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (m_drain) m_drain = 1'b0;
        else begin
          chk("fetch_addr", imem_addr, m_pc);
          sb.push_back({m_pc + 32'd4, mem_fn(m_pc)});
          m_pc = m_pc + 32'd4;
          chk("occupancy", {31'b0, sb.size() <= QDEPTH}, 32'd1);
        end
      end
      p_pend = imem_req && !imem_ack;
      p_addr = imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    bit seen;
    int r;
    rst_n = 1'b0; pc_initial = 32'h0040_0000; stall = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("boot_noreq", {31'b0, imem_req}, 32'd0);

    // Zero-wait streaming: one fetch per cycle, queue head trails by one
    step();
    @(negedge clk); chk("seq_a0", imem_addr, 32'h0040_0000);
    @(negedge clk); chk("seq_a1", imem_addr, 32'h0040_0004); chk("seq_p1", if_pc4, 32'h0040_0004);
    @(negedge clk); chk("seq_a2", imem_addr, 32'h0040_0008); chk("seq_p2", if_pc4, 32'h0040_0008);

    // Stall: one entry already queued, so only QDEPTH-1 more fetches before HOLD
    step(); stall = 1'b1; nf = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req && imem_ack) nf++;
    end
    chk("stall_fetches", nf, QDEPTH - 1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_head", if_pc4, 32'h0040_000C);
    step(); stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) begin seen = 1'b1; chk("resume_addr", imem_addr, 32'h0040_0010); end
    end
    if (!seen) chk("resume_timeout", 32'd0, 32'd1);
    repeat (3) step();

    // Redirect during a wait state: old request drained, target fetched after
    ack_en = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    step(); redirect_valid = 1'b0;
    step(); ack_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if_valid) begin seen = 1'b1; chk("drain_pc4", if_pc4, 32'h0000_1004); end
    end
    if (!seen) chk("drain_timeout", 32'd0, 32'd1);
    repeat (3) step();

    // Redirect coinciding with ack and a would-be pop
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    @(negedge clk);
    chk("rack_valid", {31'b0, if_valid}, 32'd1);
    chk("rack_ack", {31'b0, imem_ack}, 32'd1);
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("rack_empty", {31'b0, if_valid}, 32'd0);
    chk("rack_addr", imem_addr, 32'h0000_1000);

    // Misaligned redirect
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_addr", imem_addr, 32'h0000_2000);
    chk("mis_flag", {31'b0, misalign_err}, 32'd1);

    // Randomised traffic, including targets near the top of the address space
    for (int i = 0; i < 600; i++) begin
      step();
      stall  = ($urandom_range(0, 99) < 30);
      ack_en = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 6);
      r = $urandom_range(0, 9);
      if (r == 0)      redirect_pc = 32'hFFFF_FFF8;
      else if (r == 1) redirect_pc = $urandom;
      else             redirect_pc = $urandom & 32'h0000_FFFC;
    end
    step(); redirect_valid = 1'b0; stall = 1'b0; ack_en = 1'b1;
    repeat (4) step();

    // Async reset while a request waits; acks around reset must be ignored
    ack_en = 1'b0; pc_initial = 32'h0000_8000;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_pc4", if_pc4, 32'd0);
    chk("arst_mis", {31'b0, misalign_err}, 32'd0);
    ack_force = 1'b1; ack_en = 1'b1;
    step(); step(); rst_n = 1'b1;
    @(negedge clk);
    chk("arst_boot_req", {31'b0, imem_req}, 32'd0);
    step(); ack_force = 1'b0;
    @(negedge clk);
    chk("arst_refetch", imem_addr, 32'h0000_8000);
    chk("arst_nopush", {31'b0, if_valid}, 32'd0);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
